// File: rtl/draw_pkg.sv
// Shared definitions for the sprite draw scheduler: FSM encodings, screen geometry and colours.
package draw_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int COLOUR_W = 12;
   localparam int X_W      = 9;
   localparam int Y_W      = 8;

   localparam logic [COLOUR_W-1:0] BG_DEFAULT  = 12'h884;
   localparam logic [COLOUR_W-1:0] KEY_DEFAULT = 12'hF0F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SELECT,
      ST_DRAW,
      ST_DONE
   } state_e;

endpackage

// File: rtl/rect_scanner.sv
// Raster scanner over a width x height rectangle, one position per cycle after a start pulse.
// Shared by the screen clear and every sprite draw.
module rect_scanner
   import draw_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic [X_W-1:0] width_i,
   input  logic [Y_W-1:0] height_i,
   output logic [X_W-1:0] col_o,
   output logic [Y_W-1:0] row_o,
   output logic           valid_o,
   output logic           last_o
);

   logic           active_q, active_d;
   logic [X_W-1:0] col_q, col_d, col_end_q, col_end_d;
   logic [Y_W-1:0] row_q, row_d, row_end_q, row_end_d;
   logic           col_wrap;
   logic           row_wrap;

   assign col_wrap = (col_q == col_end_q);
   assign row_wrap = (row_q == row_end_q);

   always_comb begin
      active_d  = active_q;
      col_d     = col_q;
      row_d     = row_q;
      col_end_d = col_end_q;
      row_end_d = row_end_q;
      if (start_i) begin
         active_d  = 1'b1;
         col_d     = '0;
         row_d     = '0;
         col_end_d = width_i - X_W'(1);
         row_end_d = height_i - Y_W'(1);
      end else if (active_q) begin
         if (col_wrap) begin
            col_d = '0;
            if (row_wrap) begin
               active_d = 1'b0;
               row_d    = '0;
            end else begin
               row_d = row_q + Y_W'(1);
            end
         end else begin
            col_d = col_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         active_q  <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         col_end_q <= '0;
         row_end_q <= '0;
      end else begin
         active_q  <= active_d;
         col_q     <= col_d;
         row_q     <= row_d;
         col_end_q <= col_end_d;
         row_end_q <= row_end_d;
      end
   end

   assign col_o   = col_q;
   assign row_o   = row_q;
   assign valid_o = active_q;
   assign last_o  = active_q && col_wrap && row_wrap;

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sequencer: clear the screen, then draw requested sprites from a shared ROM in index order.
// Optional SPR_TRANSPARENCY_EN: sprite pixels equal to KEY_COLOUR are not plotted.
module sprite_draw_scheduler
   import draw_pkg::*;
#(
   parameter int                  NSPR       = 4,
   parameter int                  SPR_W      = 16,
   parameter int                  SPR_H      = 16,
   parameter int                  ADDR_W     = 17,
   parameter logic [COLOUR_W-1:0] BG_COLOUR  = BG_DEFAULT,
   parameter logic [COLOUR_W-1:0] KEY_COLOUR = KEY_DEFAULT
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic                  frame_tick,
   input  logic [NSPR-1:0]       req,
   input  logic [NSPR*X_W-1:0]   spr_x,
   input  logic [NSPR*Y_W-1:0]   spr_y,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [COLOUR_W-1:0]   rom_q,
   output logic [X_W-1:0]        vga_x,
   output logic [Y_W-1:0]        vga_y,
   output logic [COLOUR_W-1:0]   vga_colour,
   output logic                  vga_plot,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   localparam int IDX_W = (NSPR > 1) ? $clog2(NSPR) : 1;

`ifdef SPR_TRANSPARENCY_EN
   localparam logic KEY_EN = 1'b1;
`else
   localparam logic KEY_EN = 1'b0;
`endif

   function automatic logic [IDX_W-1:0] first_set(input logic [NSPR-1:0] m);
      first_set = '0;
      for (int i = NSPR - 1; i >= 0; i--) begin
         if (m[i]) first_set = IDX_W'(i);
      end
   endfunction

   function automatic logic off_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
      return (px >= (X_W+1)'(SCREEN_W)) || (py >= (Y_W+1)'(SCREEN_H));
   endfunction

   state_e              state_q;
   logic [NSPR-1:0]     pending_q;
   logic [IDX_W-1:0]    cur_q;
   logic [NSPR*X_W-1:0] spr_x_q;
   logic [NSPR*Y_W-1:0] spr_y_q;
   logic                busy_q;
   logic                done_q;
   logic                overrun_q;

   logic                scan_start;
   logic [X_W-1:0]      scan_w;
   logic [Y_W-1:0]      scan_h;
   logic [X_W-1:0]      scan_col;
   logic [Y_W-1:0]      scan_row;
   logic                scan_valid;
   logic                scan_last;

   logic [X_W-1:0]      base_x;
   logic [Y_W-1:0]      base_y;
   logic [X_W:0]        px_p0;
   logic [Y_W:0]        py_p0;
   logic                clip_p0;

   logic                vld_p1_q;
   logic                draw_p1_q;
   logic                clip_p1_q;
   logic [X_W-1:0]      x_p1_q;
   logic [Y_W-1:0]      y_p1_q;
   logic                key_hit_p1;

   assign scan_start = ((state_q == ST_IDLE) && frame_tick) ||
                       ((state_q == ST_SELECT) && (|pending_q));
   assign scan_w     = (state_q == ST_IDLE) ? X_W'(SCREEN_W) : X_W'(SPR_W);
   assign scan_h     = (state_q == ST_IDLE) ? Y_W'(SCREEN_H) : Y_W'(SPR_H);

   rect_scanner u_scan (
      .clk_i    (CLOCK_50),
      .rst_ni   (resetn),
      .start_i  (scan_start),
      .width_i  (scan_w),
      .height_i (scan_h),
      .col_o    (scan_col),
      .row_o    (scan_row),
      .valid_o  (scan_valid),
      .last_o   (scan_last)
   );

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         cur_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (frame_tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               if (frame_tick) begin
                  pending_q <= req;
                  busy_q    <= 1'b1;
                  state_q   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (scan_last) state_q <= ST_SELECT;
            end
            ST_SELECT: begin
               if (|pending_q) begin
                  cur_q   <= first_set(pending_q);
                  state_q <= ST_DRAW;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DRAW: begin
               if (scan_last) begin
                  pending_q[cur_q] <= 1'b0;
                  state_q          <= ST_SELECT;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Sprite positions are snapshotted at frame start so game logic may move them mid-frame
   always_ff @(posedge CLOCK_50) begin
      if ((state_q == ST_IDLE) && frame_tick) begin
         spr_x_q <= spr_x;
         spr_y_q <= spr_y;
      end
   end

   // Stage p0: raster position from the scanner, ROM address issued
   assign base_x   = (state_q == ST_DRAW) ? spr_x_q[int'(cur_q)*X_W +: X_W] : '0;
   assign base_y   = (state_q == ST_DRAW) ? spr_y_q[int'(cur_q)*Y_W +: Y_W] : '0;
   assign px_p0    = {1'b0, base_x} + {1'b0, scan_col};
   assign py_p0    = {1'b0, base_y} + {1'b0, scan_row};
   assign clip_p0  = off_screen(px_p0, py_p0);
   assign rom_addr = (state_q == ST_DRAW)
                     ? ADDR_W'(cur_q) * ADDR_W'(SPR_W * SPR_H) + ADDR_W'(scan_row) * ADDR_W'(SPR_W)
                       + ADDR_W'(scan_col)
                     : '0;

   // Stage p1: coordinates aligned with rom_q returned by the ROM
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         vld_p1_q  <= 1'b0;
         draw_p1_q <= 1'b0;
         clip_p1_q <= 1'b0;
         x_p1_q    <= '0;
         y_p1_q    <= '0;
      end else begin
         vld_p1_q  <= scan_valid;
         draw_p1_q <= (state_q == ST_DRAW);
         clip_p1_q <= clip_p0;
         x_p1_q    <= px_p0[X_W-1:0];
         y_p1_q    <= py_p0[Y_W-1:0];
      end
   end

   assign key_hit_p1 = KEY_EN && draw_p1_q && (rom_q == KEY_COLOUR);

   assign vga_x      = x_p1_q;
   assign vga_y      = y_p1_q;
   assign vga_plot   = vld_p1_q && !clip_p1_q && !key_hit_p1;
   assign vga_colour = !vld_p1_q ? '0 : (draw_p1_q ? rom_q : BG_COLOUR);
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler: one full frame with clear, three sprites and an
// overrun tick, then a second frame start, a mid-frame reset abort and a restart.
module tb_sprite_draw_scheduler;

`ifdef SPR_TRANSPARENCY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   localparam int CLEAR_N = 76800;
   localparam int DONE_N  = 76801 + 3 * 257;   // DONE cycle index after the start edge
   localparam int EXP_S0  = KEY_EN ? 255 : 256;

   logic        clk = 1'b0;
   logic        resetn;
   logic        frame_tick;
   logic [3:0]  req;
   logic [35:0] spr_x;
   logic [31:0] spr_y;
   logic [16:0] rom_addr;
   logic [11:0] rom_q;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [11:0] vga_colour;
   logic        vga_plot;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   int cmp  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(input logic [16:0] a);
      if (a == 17'd5) return 12'hF0F;
      return a[11:0] ^ 12'h5A3;
   endfunction

   always @(posedge clk) rom_q <= rom_fn(rom_addr);

   sprite_draw_scheduler dut (
      .CLOCK_50   (clk),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .req        (req),
      .spr_x      (spr_x),
      .spr_y      (spr_y),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   task automatic test_reset();
      resetn     = 1'b0;
      frame_tick = 1'b0;
      req        = 4'b0000;
      spr_x      = '0;
      spr_y      = '0;
      repeat (3) @(posedge clk);
      #1;
      cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
      cmp++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", frame_done); end
      cmp++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b want 0", overrun); end
      cmp++; if (vga_plot !== 1'b0) begin errs++; $display("FAIL reset_plot got %b want 0", vga_plot); end
      cmp++; if (vga_x !== 9'd0) begin errs++; $display("FAIL reset_x got %0d want 0", vga_x); end
      cmp++; if (vga_y !== 8'd0) begin errs++; $display("FAIL reset_y got %0d want 0", vga_y); end
      cmp++; if (vga_colour !== 12'h000) begin errs++; $display("FAIL reset_colour got %h want 000", vga_colour); end
      cmp++; if (rom_addr !== 17'd0) begin errs++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_frame();
      int sx[3];
      int sy[3];
      int bad_clear, bad_spr, bad_addr, bad_busy, bad_ovr;
      int done_cnt, done_n, outside;
      int cnt[3];
      string d_clear, d_spr, d_addr, d_busy, d_ovr;
      int k, m, s, p, ex, ey, ea;
      logic [11:0] ec;
      logic ep, eb, eo;

      sx = '{10, 312, 100};
      sy = '{20, 236, 50};
      cnt = '{0, 0, 0};
      bad_clear = 0; bad_spr = 0; bad_addr = 0; bad_busy = 0; bad_ovr = 0;
      done_cnt = 0; done_n = -1; outside = 0;
      d_clear = ""; d_spr = ""; d_addr = ""; d_busy = ""; d_ovr = "";

      req   = 4'b0111;
      spr_x = {9'd0, 9'd100, 9'd312, 9'd10};
      spr_y = {8'd0, 8'd50, 8'd236, 8'd20};
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;

      for (int n = 0; n <= DONE_N + 1; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         eb = (n <= DONE_N);
         if (busy !== eb) begin
            bad_busy++;
            if (bad_busy == 1) d_busy = $sformatf("n=%0d got %b want %b", n, busy, eb);
         end
         eo = (n > 1000);
         if (overrun !== eo) begin
            bad_ovr++;
            if (bad_ovr == 1) d_ovr = $sformatf("n=%0d got %b want %b", n, overrun, eo);
         end
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_n = n;
         end
         if (vga_plot === 1'b1 && (vga_x >= 9'd320 || vga_y >= 8'd240)) outside++;

         if (n >= 1 && n <= CLEAR_N) begin
            k  = n - 1;
            ex = k % 320;
            ey = k / 320;
            if (vga_plot !== 1'b1 || vga_x !== 9'(ex) || vga_y !== 8'(ey) || vga_colour !== 12'h884) begin
               bad_clear++;
               if (bad_clear == 1)
                  d_clear = $sformatf("n=%0d got plot=%b (%0d,%0d) %h want plot=1 (%0d,%0d) 884",
                                      n, vga_plot, vga_x, vga_y, vga_colour, ex, ey);
            end
         end else begin
            ep = 1'b0; ex = 0; ey = 0; ec = '0; s = 3;
            if (n >= CLEAR_N + 2) begin
               m = n - (CLEAR_N + 2);
               s = m / 257;
               p = m % 257;
               if (s < 3 && p < 256) begin
                  ex = sx[s] + p % 16;
                  ey = sy[s] + p / 16;
                  ec = rom_fn(17'(s * 256 + p));
                  ep = (ex < 320) && (ey < 240) && !(KEY_EN && ec == 12'hF0F);
               end else begin
                  s = 3;
               end
            end
            if (vga_plot === 1'b1 && s < 3) cnt[s]++;
            if (vga_plot !== ep || (ep && (vga_x !== 9'(ex) || vga_y !== 8'(ey) || vga_colour !== ec))) begin
               bad_spr++;
               if (bad_spr == 1)
                  d_spr = $sformatf("n=%0d got plot=%b (%0d,%0d) %h want plot=%b (%0d,%0d) %h",
                                    n, vga_plot, vga_x, vga_y, vga_colour, ep, ex, ey, ec);
            end
         end

         if (n >= CLEAR_N + 1) begin
            m = n - (CLEAR_N + 1);
            if (m / 257 < 3 && m % 257 < 256) begin
               ea = (m / 257) * 256 + m % 257;
               if (rom_addr !== 17'(ea)) begin
                  bad_addr++;
                  if (bad_addr == 1) d_addr = $sformatf("n=%0d got %0d want %0d", n, rom_addr, ea);
               end
            end
         end

         frame_tick = (n == 1000);
         if (n == 2000) begin
            spr_x[8:0] = 9'd200;
            req        = 4'b1111;
         end
      end
      frame_tick = 1'b0;

      cmp++; if (bad_busy !== 0) begin errs++; $display("FAIL frame_busy bad=%0d first: %s", bad_busy, d_busy); end
      cmp++; if (bad_ovr !== 0) begin errs++; $display("FAIL frame_overrun bad=%0d first: %s", bad_ovr, d_ovr); end
      cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL frame_done_count got %0d want 1", done_cnt); end
      cmp++; if (done_n !== DONE_N) begin errs++; $display("FAIL frame_done_cycle got %0d want %0d", done_n, DONE_N); end
      cmp++; if (bad_clear !== 0) begin errs++; $display("FAIL clear_raster bad=%0d first: %s", bad_clear, d_clear); end
      cmp++; if (bad_spr !== 0) begin errs++; $display("FAIL sprite_pixels bad=%0d first: %s", bad_spr, d_spr); end
      cmp++; if (bad_addr !== 0) begin errs++; $display("FAIL rom_addr_seq bad=%0d first: %s", bad_addr, d_addr); end
      cmp++; if (cnt[0] !== EXP_S0) begin errs++; $display("FAIL sprite0_plots got %0d want %0d", cnt[0], EXP_S0); end
      cmp++; if (cnt[1] !== 32) begin errs++; $display("FAIL sprite1_clipped_plots got %0d want 32", cnt[1]); end
      cmp++; if (cnt[2] !== 256) begin errs++; $display("FAIL sprite2_plots got %0d want 256", cnt[2]); end
      cmp++; if (outside !== 0) begin errs++; $display("FAIL offscreen_plots got %0d want 0", outside); end
   endtask

   task automatic test_next_frame();
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL next_frame_busy got %b want 1", busy); end
      cmp++; if (overrun !== 1'b1) begin errs++; $display("FAIL overrun_sticky got %b want 1", overrun); end
      @(posedge clk);
      #1;
      cmp++;
      if (vga_plot !== 1'b1 || vga_x !== 9'd0 || vga_y !== 8'd0 || vga_colour !== 12'h884) begin
         errs++;
         $display("FAIL next_frame_first_plot got plot=%b (%0d,%0d) %h want plot=1 (0,0) 884",
                  vga_plot, vga_x, vga_y, vga_colour);
      end
      repeat (50) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort();
      int bad;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", busy); end
      cmp++; if (vga_plot !== 1'b0) begin errs++; $display("FAIL abort_plot got %b want 0", vga_plot); end
      cmp++; if (overrun !== 1'b0) begin errs++; $display("FAIL abort_overrun got %b want 0", overrun); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (frame_done !== 1'b0 || busy !== 1'b0 || vga_plot !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      cmp++; if (bad !== 0) begin errs++; $display("FAIL abort_quiet bad_cycles got %0d want 0", bad); end
   endtask

   task automatic test_restart();
      int bad, ex, ey;
      string d;
      bad = 0;
      d   = "";
      req = 4'b0000;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL restart_busy got %b want 1", busy); end
      for (int j = 1; j <= 400; j++) begin
         @(posedge clk);
         #1;
         ex = (j - 1) % 320;
         ey = (j - 1) / 320;
         if (vga_plot !== 1'b1 || vga_x !== 9'(ex) || vga_y !== 8'(ey) || vga_colour !== 12'h884 ||
             busy !== 1'b1 || overrun !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            if (bad == 1)
               d = $sformatf("j=%0d got plot=%b (%0d,%0d) %h busy=%b ovr=%b want (%0d,%0d)",
                             j, vga_plot, vga_x, vga_y, vga_colour, busy, overrun, ex, ey);
         end
      end
      cmp++; if (bad !== 0) begin errs++; $display("FAIL restart_raster bad=%0d first: %s", bad, d); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_next_frame();
      test_reset_abort();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
